stoch_decorr_sched: RTL

Round-robin scheduler that shares one decorrelation engine and one 64-bit LFSR random source among NUM_CH stochastic bitstream channels. Each channel keeps its own counter and 2-bit delay buffer. A valid/ready handshake admits at most one input bit per cycle. The block sits between bitstream producers and downstream stochastic arithmetic, where several streams need decorrelating but one dedicated decorrelator per stream costs too much area.

---
 rtl/stoch_decorr_sched_if.sv | 29 ++
 rtl/stoch_decorr_sched.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/stoch_decorr_sched_if.sv
// Handshake bundle between bitstream producers/consumers and the shared decorrelation scheduler.
interface stoch_decorr_sched_if #(
  parameter int unsigned NUM_CH = 4
) ();
  logic [NUM_CH-1:0] in_valid;
  logic [NUM_CH-1:0] in_bit;
  logic [NUM_CH-1:0] in_ready;
  logic [NUM_CH-1:0] flush;
  logic [NUM_CH-1:0] out_valid;
  logic [NUM_CH-1:0] out_bit;

  modport master (
    output in_valid,
    output in_bit,
    output flush,
    input  in_ready,
    input  out_valid,
    input  out_bit
  );

  modport slave (
    input  in_valid,
    input  in_bit,
    input  flush,
    output in_ready,
    output out_valid,
    output out_bit
  );
endinterface

// File: rtl/stoch_decorr_sched.sv
// Round-robin scheduler sharing one decorrelator and one 64-bit LFSR among NUM_CH bitstreams.
// The LFSR (x^64 + x^63 + x^61 + x^60 + 1, seed 1) free-runs every cycle.
module fibonacci_lfsr_64 (
  input  logic        CLK,
  input  logic        nRST,
  output logic [63:0] r_o
);
  localparam logic [63:0] Seed = 64'h1;

  logic [63:0] r_q, r_d;

  always_comb begin
    r_d = {r_q[62:0], r_q[63] ^ r_q[62] ^ r_q[60] ^ r_q[59]};
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_q <= Seed;
    end else begin
      r_q <= r_d;
    end
  end

  assign r_o = r_q;
endmodule

module stoch_decorr_sched #(
  parameter int unsigned NUM_CH       = 4,
  parameter int unsigned COUNTER_SIZE = 8,
  parameter int unsigned STEP_VAL     = 16
) (
  input  logic                CLK,
  input  logic                nRST,
  stoch_decorr_sched_if.slave bus
);
  localparam int unsigned IdxW = $clog2(NUM_CH);
  localparam logic [COUNTER_SIZE-1:0] Step  = COUNTER_SIZE'(STEP_VAL);
  localparam logic [COUNTER_SIZE:0]   StepW = (COUNTER_SIZE + 1)'(STEP_VAL);
  localparam logic [COUNTER_SIZE:0]   MaxW  = {1'b0, {COUNTER_SIZE{1'b1}}};

  logic [COUNTER_SIZE-1:0] cnt_q [NUM_CH];
  logic [COUNTER_SIZE-1:0] cnt_d [NUM_CH];
  logic [1:0]              buf_q [NUM_CH];
  logic [1:0]              buf_d [NUM_CH];
  logic [IdxW-1:0]         last_q, last_d;
  logic [NUM_CH-1:0]       out_valid_q, out_valid_d;
  logic [NUM_CH-1:0]       out_bit_q, out_bit_d;

  logic [63:0]             lfsr;
  logic                    lfsr_unused;
  logic [COUNTER_SIZE-1:0] rnd;

  fibonacci_lfsr_64 u_lfsr (
    .CLK  (CLK),
    .nRST (nRST),
    .r_o  (lfsr)
  );

  assign rnd         = lfsr[COUNTER_SIZE-1:0];
  assign lfsr_unused = ^lfsr[63:COUNTER_SIZE];

  // Arbiter: first valid, unflushed channel after last_q wins.
  logic [NUM_CH-1:0] grant;
  logic [IdxW-1:0]   grant_idx, cand_idx;
  logic              xfer;

  always_comb begin
    grant     = '0;
    grant_idx = last_q;
    cand_idx  = '0;
    xfer      = 1'b0;
    for (int unsigned i = 1; i <= NUM_CH; i++) begin
      cand_idx = IdxW'((32'(last_q) + i) % NUM_CH);
      if (!xfer && nRST && bus.in_valid[cand_idx] && !bus.flush[cand_idx]) begin
        xfer            = 1'b1;
        grant[cand_idx] = 1'b1;
        grant_idx       = cand_idx;
      end
    end
  end

  // Shared decorrelation datapath, evaluated for the granted channel only.
  logic [COUNTER_SIZE-1:0] cur_cnt, sat_cnt, new_cnt;
  logic [COUNTER_SIZE:0]   sum;
  logic [1:0]              cur_buf;
  logic                    y, a, shift_in;

  always_comb begin
    cur_cnt  = cnt_q[grant_idx];
    cur_buf  = buf_q[grant_idx];
    y        = cur_buf[1];
    a        = bus.in_bit[grant_idx];
    sum      = {1'b0, cur_cnt} + (a ? StepW : '0);
    sat_cnt  = (sum > MaxW) ? MaxW[COUNTER_SIZE-1:0] : sum[COUNTER_SIZE-1:0];
    if (y && (sat_cnt < Step)) begin
      new_cnt = '0;
    end else begin
      new_cnt = sat_cnt - (y ? Step : '0);
    end
    shift_in = (rnd <= cur_cnt);
  end

  always_comb begin
    last_d      = xfer ? grant_idx : last_q;
    out_valid_d = grant;
    out_bit_d   = out_bit_q;
    if (xfer) begin
      out_bit_d[grant_idx] = y;
    end
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      cnt_d[k] = cnt_q[k];
      buf_d[k] = buf_q[k];
      if (bus.flush[k]) begin
        cnt_d[k] = '0;
        buf_d[k] = '0;
      end else if (grant[k]) begin
        cnt_d[k] = new_cnt;
        buf_d[k] = {cur_buf[0], shift_in};
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      for (int unsigned k = 0; k < NUM_CH; k++) begin
        cnt_q[k] <= '0;
        buf_q[k] <= '0;
      end
      last_q      <= IdxW'(NUM_CH - 1);
      out_valid_q <= '0;
      out_bit_q   <= '0;
    end else begin
      for (int unsigned k = 0; k < NUM_CH; k++) begin
        cnt_q[k] <= cnt_d[k];
        buf_q[k] <= buf_d[k];
      end
      last_q      <= last_d;
      out_valid_q <= out_valid_d;
      out_bit_q   <= out_bit_d;
    end
  end

  assign bus.in_ready  = grant;
  assign bus.out_valid = out_valid_q;
  assign bus.out_bit   = out_bit_q;
endmodule
